// File: rtl/byte_ram_ctrl.sv
// Byte-addressable RAM controller over a 32-bit little-endian word store.
// Supports byte/half/word loads and stores, misaligned accesses split over two words.
module byte_ram_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2 ** (ADDR_W - 2)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_bmask,
    input  logic              i_unsigned,
    output logic              o_ready,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic [1:0]        o_state
);

    localparam int WW = ADDR_W - 2;

    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] SPLIT = 2'd2;

    logic [31:0]   mem [DEPTH];
    logic [1:0]    state;
    logic [WW-1:0] cnt;

    // Context of an accepted request, consumed by the SPLIT cycle
    logic [WW-1:0] hi_q;
    logic [1:0]    off_q;
    logic [3:0]    bm_q;
    logic          uns_q;
    logic          wren_q;
    logic [31:0]   wd_hi_q;
    logic [3:0]    mk_hi_q;
    logic [31:0]   lo_q;

    logic [WW-1:0] widx;
    logic [WW-1:0] widx_nx;
    logic [1:0]    off;
    logic          legal;
    logic          split;
    logic          accept;
    logic [7:0]    mask8;
    logic [63:0]   wide;

    // Handshake: a request is taken on a rising edge where i_req and o_ready are both 1;
    // o_rvalid and o_err are single-cycle pulses with no backpressure.
    assign o_ready = (state == IDLE) && !i_reset;
    assign o_state = state;
    assign accept  = i_req && o_ready;

    assign widx    = i_addr[ADDR_W-1:2];
    assign off     = i_addr[1:0];
    assign widx_nx = (widx == WW'(DEPTH - 1)) ? '0 : widx + 1'b1;
    assign legal   = (i_bmask == 4'b0001) || (i_bmask == 4'b0011) || (i_bmask == 4'b1111);
    assign mask8   = {4'b0000, i_bmask} << off;
    assign wide    = {32'h0, i_wdata} << {off, 3'b000};
    assign split   = |mask8[7:4];

    function automatic logic [31:0] fmt(input logic [63:0] w, input logic [1:0] boff,
                                        input logic [3:0] bm, input logic uns);
        logic [63:0] sh;
        logic [31:0] r;
        sh = w >> {boff, 3'b000};
        r  = sh[31:0];
        case (bm)
            4'b0001: r = {{24{~uns & r[7]}}, r[7:0]};
            4'b0011: r = {{16{~uns & r[15]}}, r[15:0]};
            default: ;
        endcase
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (accept && i_wren && legal) begin
                for (int l = 0; l < 4; l++)
                    if (mask8[l]) mem[widx][8*l +: 8] <= wide[8*l +: 8];
            end else if (state == SPLIT && wren_q) begin
                for (int l = 0; l < 4; l++)
                    if (mk_hi_q[l]) mem[hi_q][8*l +: 8] <= wd_hi_q[8*l +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            hi_q    <= widx_nx;
            off_q   <= off;
            bm_q    <= i_bmask;
            uns_q   <= i_unsigned;
            wren_q  <= i_wren;
            wd_hi_q <= wide[63:32];
            mk_hi_q <= mask8[7:4];
            lo_q    <= mem[widx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= CLEAR;
            cnt      <= '0;
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WW'(DEPTH - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (i_req) begin
                        if (!legal) begin
                            o_err <= 1'b1;
                        end else if (split) begin
                            state <= SPLIT;
                        end else if (!i_wren) begin
                            o_rvalid <= 1'b1;
                            o_rdata  <= fmt({32'h0, mem[widx]}, off, i_bmask, i_unsigned);
                        end
                    end
                end
                SPLIT: begin
                    state <= IDLE;
                    if (!wren_q) begin
                        o_rvalid <= 1'b1;
                        o_rdata  <= fmt({mem[hi_q], lo_q}, off_q, bm_q, uns_q);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: doc/byte_ram_ctrl.md
BYTE_RAM_CTRL -- requirements
Module: byte_ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning byte-address width.
REQ-002 The block SHALL have parameter DEPTH, default 2**(ADDR_W-2), meaning storage size in 32-bit words.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_req, input, 1 bit: request valid.
REQ-006 The block SHALL have port i_wren, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port i_addr, input, ADDR_W bits: byte address.
REQ-008 The block SHALL have port i_wdata, input, 32 bits: store data, LSB-aligned.
REQ-009 The block SHALL have port i_bmask, input, 4 bits: access size; 0001 = byte, 0011 = half, 1111 = word.
REQ-010 The block SHALL have port i_unsigned, input, 1 bit: 1 = zero-extend load, 0 = sign-extend load.
REQ-011 The block SHALL have port o_ready, output, 1 bit: request accepted when i_req & o_ready.
REQ-012 The block SHALL have port o_rvalid, output, 1 bit: one-cycle pulse, load data valid.
REQ-013 The block SHALL have port o_rdata, output, 32 bits: load result.
REQ-014 The block SHALL have port o_err, output, 1 bit: one-cycle pulse, illegal i_bmask on an accepted request.

Function
REQ-015 Storage SHALL be DEPTH x 32-bit words, little-endian: byte at address A is in word A[ADDR_W-1:2], lane A[1:0].
REQ-016 An access SHALL cover bytes A .. A+N-1 (N = 1, 2 or 4 per i_bmask), and byte k of i_wdata SHALL map to address A+k.
REQ-017 An access SHALL be aligned when all of its bytes fall in one word, and misaligned (split) otherwise.
REQ-018 The FSM SHALL have states CLEAR, IDLE and SPLIT.
REQ-019 In CLEAR, the block SHALL zero one word per cycle using a word counter from 0 to DEPTH-1, hold o_ready=0, and enter IDLE after writing word DEPTH-1.
REQ-020 In IDLE, o_ready SHALL be 1.
REQ-021 An accepted aligned store SHALL write only the addressed lanes in the accept cycle and the FSM SHALL remain in IDLE.
REQ-022 An accepted aligned load SHALL produce o_rvalid=1 with o_rdata in the cycle after accept (1-cycle latency).
REQ-023 An accepted misaligned access SHALL handle the lower word in the accept cycle and the upper word (word index +1) in the SPLIT cycle.
REQ-024 The SPLIT cycle SHALL hold o_ready=0 and return to IDLE afterwards.
REQ-025 A misaligned load SHALL assert o_rvalid in the cycle after SPLIT (2-cycle latency).
REQ-026 A misaligned access to word DEPTH-1 SHALL wrap its upper half to word 0.
REQ-027 A load result SHALL be the N bytes right-justified, with upper bits equal to 0 if i_unsigned=1 and to replicated bit 8N-1 if i_unsigned=0; a word load SHALL return all 32 bits unmodified.
REQ-028 Request fields SHALL be registered at accept; inputs during SPLIT SHALL be ignored.
REQ-029 Any other i_bmask value on an accepted request SHALL pulse o_err in the next cycle, with no write and no o_rvalid.
REQ-030 o_rdata SHALL hold its last value between o_rvalid pulses.
REQ-031 Back-to-back aligned requests SHALL be accepted every cycle.
REQ-032 A load to an address stored in the immediately preceding cycle SHALL return the new data.

Reset
REQ-033 While i_reset=1: the state SHALL be CLEAR with counter 0, o_ready=0, o_rvalid=0, o_err=0 and o_rdata=0.
REQ-034 Reset asserted mid-CLEAR or mid-SPLIT SHALL abort the operation; any pending load SHALL be dropped with no o_rvalid.
REQ-035 After i_reset deasserts, o_ready SHALL rise exactly DEPTH cycles later.

Verification
REQ-036 Bench SHALL check: release reset, count cycles -> o_ready rises after DEPTH (512) cycles; word load of address 400 -> 0x00000000.
REQ-037 Bench SHALL check: word store 0xDEADBEEF @400, then byte load @403 with i_unsigned=1 -> 0x000000DE; with i_unsigned=0 -> 0xFFFFFFDE; half load @402 unsigned -> 0x0000DEAD.
REQ-038 Bench SHALL check: word store 0x11223344 @5 -> o_ready low one cycle; word load @5 -> 0x11223344 with 2-cycle latency; word @4 reads 0x22334400 (bytes 5..7 = 44,33,22; byte 4 untouched, 0).
REQ-039 Bench SHALL check: with ADDR_W=11, half store 0xBEEF @2047 -> byte 2047 = 0xEF, byte 0 = 0xBE; half load @2047 unsigned -> 0x0000BEEF.
REQ-040 Bench SHALL check: bmask 0101 store -> o_err pulse, memory unchanged; then back-to-back loads @400, @401 -> o_rvalid on two consecutive cycles.
REQ-041 Bench SHALL check: reset asserted during SPLIT of a misaligned load -> no o_rvalid; after re-clear, load @400 -> 0x00000000.
